mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage pipeline, between the EX/M pipeline register and the M/WB register. It drives a data memory over a request/ready handshake and performs byte/halfword/word alignment, load sign/zero extension and store lane steering. It feeds the M/WB register the read data, ALU result, destination register and writeback controls. While an access is outstanding it raises a stall that freezes the upstream pipeline.

## Interface
- `data_size`, 32: datapath width. Only 32 is supported.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Reset is asserted when `rst`=0.
- `M_MemRead`, `M_MemWrite` in 1 each: access type of the instruction in M.
- `M_MemtoReg`, `M_RegWrite` in 1 each: writeback controls from EX/M.
- `M_Mem_Size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `M_Mem_Unsigned` in 1: zero-extend loads when 1.
- `M_ALU_out` in 32: effective address, or the result for non-memory ops.
- `M_Store_Data` in 32: store source (rt).
- `M_WR_out` in 5: destination register.
- `DM_req` out 1: memory request, registered.
- `DM_we` out 1: memory write enable, registered.
- `DM_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`, registered.
- `DM_wdata` out 32: store data, registered.
- `DM_be` out 4: byte enables, registered.
- `DM_rdata` in 32: read word from memory.
- `DM_ready` in 1: memory completion.
- `MW_DM_Read_Data` out 32: to M/WB.
- `MW_WD_out` out 32: to M/WB.
- `MW_WR_out` out 5: to M/WB.
- `MW_MemtoReg` out 1: to M/WB.
- `MW_RegWrite` out 1: to M/WB.
- `M_Stall` out 1: freeze PC, IF/ID, ID/EX and EX/M.
- `M_Misalign` out 1: misaligned access flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE, aligned access pending** (`MemRead|MemWrite`):
  - Register `DM_addr`, `DM_we=MemWrite`, `DM_be`, `DM_wdata`; set `DM_req`=1.
  - Go to BUSY. `M_Stall`=1 this cycle.
- **BUSY:**
  - `M_Stall`=1. `DM_*` outputs hold stable.
  - When `DM_ready`=1 at a rising edge: clear `DM_req`, capture the aligned/extended read data into `rdata_q` (writes capture 0), go to DONE.
- **DONE:**
  - `M_Stall`=0 and `MW_DM_Read_Data`=`rdata_q`; the pipeline advances.
  - Next edge always returns to IDLE, even if the newly arrived instruction is a memory op. That instruction is then evaluated in IDLE.
- **Non-memory instruction:** pass-through, no stall, no request.
- **Alignment:** a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - `M_Misalign`=1 (combinational, while the instruction is in M).
  - No request is issued, no stall, `MW_RegWrite`=0.
- **Both MemRead and MemWrite set:** a write is performed and MemRead is ignored.
- **Store steering** (little-endian, k=`addr[1:0]`):
  - Byte: `be`=1<<k, `wdata`={4{b}}.
  - Half: `be`=0011 or 1100, `wdata`={2{h}}.
  - Word: `be`=1111.
- **Load extraction:** byte lane k (or half lane `addr[1]`), then sign-extended, or zero-extended if `M_Mem_Unsigned`.
- **Writeback outputs:**
  - `MW_WD_out`=`M_ALU_out`; `MW_WR_out`, `MW_MemtoReg` pass through.
  - `MW_RegWrite`=`M_RegWrite & ~M_Stall & ~M_Misalign`. While stalled, M/WB therefore receives bubbles and the register file is never written with incomplete data.

## Timing
- **Reset values:**
  - State IDLE; `rdata_q`=0.
  - `DM_req`, `DM_we`, `DM_addr`, `DM_wdata`, `DM_be` all 0.
  - `M_Stall`=0, `MW_RegWrite`=0 (forced while `rst`=0); remaining MW outputs follow their inputs.
- **Latency:** memory op = 1 (IDLE) + N (BUSY, N≥1 until ready) + 1 (DONE) cycles. A zero-wait memory costs 3 cycles, i.e. 2 stall cycles.
- **Handshake:** `DM_req` stays high until `DM_ready` is sampled. Address, data, we and be are constant during `DM_req`. `DM_ready` outside BUSY is ignored.
- **Reset mid-access:** immediate return to IDLE with `DM_req`=0. The in-flight memory transaction is abandoned and its late `DM_ready` is ignored.
- **Back-to-back memory ops:** each takes the full IDLE/BUSY/DONE sequence; there is no overlap.

## Structure
- Package `mem_pkg`:
  - Size codes `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - FSM state encoding.
  - `data_size` default.
- Sub-module `mem_load_align` (combinational): `DM_rdata`, `addr[1:0]`, size, unsigned → 32-bit load value. The FSM, store steering and misalign check stay in `mem_stage`.

## Test plan
- **lw, zero-wait:** `addr`=0x100, `DM_rdata`=0xDEADBEEF, ready the cycle after req.
  - `M_Stall` high for 2 cycles; then `MW_DM_Read_Data`=0xDEADBEEF and `MW_RegWrite`=1 for one cycle.
  - `DM_addr`=0x100, `DM_be`=1111.
- **lb/lbu:** `addr`=0x103, `DM_rdata`=0x80FF_FFFF.
  - lb → 0xFFFFFF80; lbu → 0x00000080.
- **sh:** `addr`=0x202, `M_Store_Data`=0x1234ABCD.
  - `DM_we`=1, `DM_be`=1100, `DM_wdata`=0xABCDABCD, `DM_addr`=0x200.
- **Wait states:** lw with `DM_ready` delayed 5 cycles.
  - `DM_req`/`DM_addr` stable throughout; stall lasts 6 cycles; `MW_RegWrite`=0 until DONE.
- **Misaligned:** lw at `addr`=0x102.
  - `M_Misalign`=1, `DM_req` stays 0, `M_Stall`=0, `MW_RegWrite`=0.
- **Reset during BUSY:** drive `rst`=0 with `DM_ready` arriving 1 cycle later.
  - `DM_req`=0 immediately, state IDLE, `rdata_q`=0.
  - The late ready produces no writeback.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage: access size codes, FSM state
// encoding and the datapath width.
package mem_pkg;

   localparam int DATA_SIZE = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the memory stage (master) and the
// data memory (slave).
interface mem_stage_if;
   import mem_pkg::*;

   logic                 DM_req;
   logic                 DM_we;
   logic [DATA_SIZE-1:0] DM_addr;
   logic [DATA_SIZE-1:0] DM_wdata;
   logic [3:0]           DM_be;
   logic [DATA_SIZE-1:0] DM_rdata;
   logic                 DM_ready;

   modport master (
      output DM_req, DM_we, DM_addr, DM_wdata, DM_be,
      input  DM_rdata, DM_ready
   );

   modport slave (
      input  DM_req, DM_we, DM_addr, DM_wdata, DM_be,
      output DM_rdata, DM_ready
   );

endinterface

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/halfword lane out of the
// memory word and sign- or zero-extends it to 32 bits.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addrLo,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_loadData
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addrLo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // Size code 11 falls into the word case.
   always_comb begin
      o_loadData = i_rdata;
      case (i_size)
         SZ_BYTE: o_loadData = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_loadData = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_loadData = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests, steers store
// lanes, aligns loads and stalls the upstream pipeline while an access is open.
module mem_stage
   import mem_pkg::*;
#(
   parameter int data_size = DATA_SIZE
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 M_MemRead,
   input  logic                 M_MemWrite,
   input  logic                 M_MemtoReg,
   input  logic                 M_RegWrite,
   input  logic [1:0]           M_Mem_Size,
   input  logic                 M_Mem_Unsigned,
   input  logic [data_size-1:0] M_ALU_out,
   input  logic [data_size-1:0] M_Store_Data,
   input  logic [4:0]           M_WR_out,
   mem_stage_if.master          dm,
   output logic [data_size-1:0] MW_DM_Read_Data,
   output logic [data_size-1:0] MW_WD_out,
   output logic [4:0]           MW_WR_out,
   output logic                 MW_MemtoReg,
   output logic                 MW_RegWrite,
   output logic                 M_Stall,
   output logic                 M_Misalign
);

   logic [1:0]           r_state;
   logic                 r_req;
   logic                 r_we;
   logic [data_size-1:0] r_addr;
   logic [data_size-1:0] r_wdata;
   logic [3:0]           r_be;
   logic [data_size-1:0] r_rdataQ;

   logic                 w_memOp;
   logic                 w_misalign;
   logic                 w_start;
   logic [3:0]           w_be;
   logic [data_size-1:0] w_wdata;
   logic [data_size-1:0] w_loadData;

   assign w_memOp = M_MemRead | M_MemWrite;

   always_comb begin
      w_misalign = 1'b0;
      if (w_memOp) begin
         case (M_Mem_Size)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = M_ALU_out[0];
            default: w_misalign = |M_ALU_out[1:0];
         endcase
      end
   end

   // Little-endian lane steering; data is replicated so any lane sees it.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = M_Store_Data;
      case (M_Mem_Size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << M_ALU_out[1:0];
            w_wdata = {4{M_Store_Data[7:0]}};
         end
         SZ_HALF: begin
            w_be    = M_ALU_out[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{M_Store_Data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = M_Store_Data;
         end
      endcase
   end

   mem_load_align u_loadAlign (
      .i_rdata    (dm.DM_rdata),
      .i_addrLo   (M_ALU_out[1:0]),
      .i_size     (M_Mem_Size),
      .i_unsigned (M_Mem_Unsigned),
      .o_loadData (w_loadData)
   );

   assign w_start = (r_state == ST_IDLE) & w_memOp & ~w_misalign;

   // DONE always falls back to IDLE so a following memory op restarts cleanly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= 4'b0000;
         r_rdataQ <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_req   <= 1'b1;
                  r_we    <= M_MemWrite;
                  r_addr  <= {M_ALU_out[data_size-1:2], 2'b00};
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (dm.DM_ready) begin
                  r_req    <= 1'b0;
                  r_rdataQ <= r_we ? '0 : w_loadData;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dm.DM_req   = r_req;
   assign dm.DM_we    = r_we;
   assign dm.DM_addr  = r_addr;
   assign dm.DM_wdata = r_wdata;
   assign dm.DM_be    = r_be;

   assign M_Stall         = rst & (w_start | (r_state == ST_BUSY));
   assign M_Misalign      = w_misalign;
   assign MW_DM_Read_Data = r_rdataQ;
   assign MW_WD_out       = M_ALU_out;
   assign MW_WR_out       = M_WR_out;
   assign MW_MemtoReg     = M_MemtoReg;
   assign MW_RegWrite     = rst & M_RegWrite & ~M_Stall & ~w_misalign;

endmodule
